// File: rtl/ram_writer_pkg.sv
// Shared definitions for the byte-stream RAM writer: bank geometry, FSM states,
// and a constant-friendly ceil_log2 helper.
package ram_writer_pkg;

  localparam int unsigned RAM_BANK_WORDS = 256;

  typedef enum logic [1:0] {
    StIdle,
    StLow,
    StHigh,
    StFull
  } wr_state_e;

  function automatic int unsigned ceil_log2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_writer_if.sv
// Byte-stream valid/ready channel feeding the RAM writer.
interface ram_writer_if;

  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/SB_RAM256x16.sv
// Behavioural model of the iCE40 256x16 block RAM primitive (MASK bit set = keep old bit).
module SB_RAM256x16 (
  output logic [15:0] RDATA,
  input  logic [7:0]  RADDR,
  input  logic        RCLK,
  input  logic        RCLKE,
  input  logic        RE,
  input  logic [7:0]  WADDR,
  input  logic        WCLK,
  input  logic        WCLKE,
  input  logic [15:0] WDATA,
  input  logic        WE,
  input  logic [15:0] MASK
);

  logic [15:0] mem [256];

  always_ff @(posedge WCLK) begin
    if (WCLKE && WE) begin
      mem[WADDR] <= (WDATA & ~MASK) | (mem[WADDR] & MASK);
    end
  end

  always_ff @(posedge RCLK) begin
    if (RCLKE && RE) begin
      RDATA <= mem[RADDR];
    end
  end

endmodule

// File: rtl/ram_bank_array.sv
// Array of 256x16 RAM banks with a single write port and a registered-index read mux,
// so the read side behaves like the ROM reader (one-cycle latency, holds when disabled).
module ram_bank_array
  import ram_writer_pkg::*;
#(
  parameter int unsigned NUM_BANKS  = 1,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [15:0]           wdata_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                  rd_clke_i,
  output logic [15:0]           rd_data_o
);

  localparam int unsigned BankW = (NUM_BANKS > 1) ? ceil_log2(NUM_BANKS) : 1;

  logic [BankW-1:0] wr_bank;
  logic [BankW-1:0] rd_bank;
  logic [BankW-1:0] rd_bank_d, rd_bank_q;
  logic [15:0]      bank_rdata [NUM_BANKS];

  if (ADDR_WIDTH > 8) begin : g_multi
    assign wr_bank = BankW'(waddr_i[ADDR_WIDTH-1:8]);
    assign rd_bank = BankW'(rd_addr_i[ADDR_WIDTH-1:8]);
  end else begin : g_single
    assign wr_bank = '0;
    assign rd_bank = '0;
  end

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    logic bank_we;
    assign bank_we = we_i && (wr_bank == BankW'(i));

    SB_RAM256x16 u_ram (
      .RDATA (bank_rdata[i]),
      .RADDR (rd_addr_i[7:0]),
      .RCLK  (clk_i),
      .RCLKE (rd_clke_i),
      .RE    (rd_clke_i && (rd_bank == BankW'(i))),
      .WADDR (waddr_i[7:0]),
      .WCLK  (clk_i),
      .WCLKE (bank_we),
      .WDATA (wdata_i),
      .WE    (bank_we),
      .MASK  (16'h0000)
    );
  end

  always_comb begin
    rd_bank_d = rd_clke_i ? rd_bank : rd_bank_q;
  end

  always_ff @(posedge clk_i) begin
    rd_bank_q <= rd_bank_d;
  end

  // Mux by the index captured with the read, not the live address.
  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (rd_bank_q == BankW'(i)) rd_data_o = bank_rdata[i];
    end
  end

endmodule

// File: rtl/ram_writer.sv
// Packs a byte stream (low byte first) into 16-bit words and writes them sequentially
// into block RAM; the filled buffer is read back through a ROM-style synchronous port.
module ram_writer
  import ram_writer_pkg::*;
#(
  parameter int unsigned VECTOR_LENGTH = 256,
  parameter logic [7:0]  PAD_BYTE      = 8'h00,
  localparam int unsigned ADDR_WIDTH   = ceil_log2(VECTOR_LENGTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  flush_i,
  ram_writer_if.slave           in_if,
  output logic [ADDR_WIDTH:0]   words_o,
  output logic                  full_o,
  output logic                  busy_o,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                  rd_clke_i,
  output logic [15:0]           rd_data_o
);

  localparam int unsigned NumBanks = VECTOR_LENGTH / RAM_BANK_WORDS;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(VECTOR_LENGTH - 1);

  wr_state_e             state_d, state_q;
  logic [7:0]            lo_d, lo_q;
  logic [ADDR_WIDTH-1:0] wptr_d, wptr_q;
  logic [ADDR_WIDTH:0]   words_d, words_q;
  logic                  we_d, we_q;
  logic [ADDR_WIDTH-1:0] waddr_d, waddr_q;
  logic [15:0]           wdata_d, wdata_q;

  logic        in_ready;
  logic        xfer;
  logic        commit;
  logic [15:0] commit_word;

  assign xfer = in_if.valid && in_ready && !start_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      lo_q    <= '0;
      wptr_q  <= '0;
      words_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      wptr_q  <= wptr_d;
      words_q <= words_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    wptr_d      = wptr_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    words_d     = we_q ? words_q + 1'b1 : words_q;
    commit      = 1'b0;
    commit_word = {PAD_BYTE, lo_q};

    if (start_i) begin
      state_d = StLow;
      wptr_d  = '0;
      lo_d    = '0;
      words_d = '0;
    end else begin
      unique case (state_q)
        StLow: begin
          if (xfer && flush_i) begin
            commit      = 1'b1;
            commit_word = {PAD_BYTE, in_if.data};
            state_d     = StIdle;
          end else if (xfer) begin
            lo_d    = in_if.data;
            state_d = StHigh;
          end else if (flush_i) begin
            state_d = StIdle;
          end
        end
        StHigh: begin
          if (xfer) begin
            commit      = 1'b1;
            commit_word = {in_if.data, lo_q};
            state_d     = flush_i ? StIdle : StLow;
          end else if (flush_i) begin
            commit  = 1'b1;
            state_d = StIdle;
          end
        end
        default: ;
      endcase

      // The pointer stops at the last word; FULL holds until the next start.
      if (commit) begin
        we_d    = 1'b1;
        waddr_d = wptr_q;
        wdata_d = commit_word;
        if (wptr_q == LastAddr) begin
          state_d = StFull;
        end else begin
          wptr_d = wptr_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    in_ready = (state_q == StLow) || (state_q == StHigh);
    busy_o   = in_ready;
    full_o   = (state_q == StFull);
    words_o  = words_q;
  end

  assign in_if.ready = in_ready;

  ram_bank_array #(
    .NUM_BANKS  (NumBanks),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_banks (
    .clk_i     (clk_i),
    .we_i      (we_q),
    .waddr_i   (waddr_q),
    .wdata_i   (wdata_q),
    .rd_addr_i (rd_addr_i),
    .rd_clke_i (rd_clke_i),
    .rd_data_o (rd_data_o)
  );

endmodule
